// File: rtl/pwm_mixer.sv
// Multi-channel PWM audio mixer: double-buffered per-channel samples, saturating
// attenuated mix and a registered PWM output whose duty updates only at period wrap.
module pwm_mixer #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic [CHANNELS-1:0]       sample_valid,
  input  logic [CHANNELS-1:0]       ch_enable,
  input  logic [1:0]                gain_shift,
  input  logic                      clear_ovf,
  output logic                      pwm_out,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       sample_ack,
  output logic                      overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // Three guard bits hold the sum of up to eight full-scale channels.
  localparam int SW = WIDTH + 3;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]       prescaler;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    duty;
  logic [WIDTH-1:0]    stage  [CHANNELS];
  logic [WIDTH-1:0]    active [CHANNELS];
  logic [CHANNELS-1:0] staged;

  logic                tick;
  logic                wrap;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       shifted;
  logic                saturate;
  logic [WIDTH-1:0]    duty_next;

  assign tick = (prescaler == PRE_MAX);
  assign wrap = tick && (cnt == CNT_MAX);

  // The mix sees each channel's value as it will be after this wrap's transfer.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_enable[i]) begin
        sum = sum + SW'(staged[i] ? stage[i] : active[i]);
      end
    end
    shifted   = sum >> gain_shift;
    saturate  = (shifted > SW'(CNT_MAX));
    duty_next = saturate ? CNT_MAX : shifted[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler    <= '0;
      cnt          <= '0;
      staged       <= '0;
      duty         <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      sample_ack   <= '0;
      overflow     <= 1'b0;
      // NOTE: the sample buffers are small flop arrays, reset so an aborted period leaves nothing behind.
      for (int i = 0; i < CHANNELS; i++) begin
        stage[i]  <= '0;
        active[i] <= '0;
      end
    end else begin
      prescaler    <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      pwm_out      <= (cnt < duty);
      period_start <= wrap;
      sample_ack   <= wrap ? staged : '0;

      if (wrap) begin
        duty <= duty_next;
      end

      if (wrap && saturate) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end

      // A load coinciding with wrap re-stages for the next period while the old stage transfers.
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrap && staged[i]) begin
          active[i] <= stage[i];
        end
        if (sample_valid[i]) begin
          stage[i]  <= sample_in[i*WIDTH +: WIDTH];
          staged[i] <= 1'b1;
        end else if (wrap) begin
          staged[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_mixer.sv
// Self-checking bench for pwm_mixer: directed and randomized periods against a
// period-level reference model, plus a PRESCALE=3 instance for tick stretching and reset abort.
module tb_pwm_mixer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with PRESCALE=1
  logic        rst_n;
  logic [31:0] sample_in;
  logic [3:0]  sample_valid;
  logic [3:0]  ch_enable;
  logic [1:0]  gain_shift;
  logic        clear_ovf;
  logic        pwm_out;
  logic        period_start;
  logic [3:0]  sample_ack;
  logic        overflow;

  // Instance with PRESCALE=3
  logic        p3_rst_n;
  logic [31:0] p3_sample_in;
  logic [3:0]  p3_sample_valid;
  logic [3:0]  p3_ch_enable;
  logic [1:0]  p3_gain_shift;
  logic        p3_clear_ovf;
  logic        p3_pwm_out;
  logic        p3_period_start;
  logic [3:0]  p3_sample_ack;
  logic        p3_overflow;

  pwm_mixer #(.WIDTH(8), .CHANNELS(4), .PRESCALE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .ch_enable    (ch_enable),
    .gain_shift   (gain_shift),
    .clear_ovf    (clear_ovf),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .sample_ack   (sample_ack),
    .overflow     (overflow)
  );

  pwm_mixer #(.WIDTH(8), .CHANNELS(4), .PRESCALE(3)) dut_p3 (
    .clk          (clk),
    .rst_n        (p3_rst_n),
    .sample_in    (p3_sample_in),
    .sample_valid (p3_sample_valid),
    .ch_enable    (p3_ch_enable),
    .gain_shift   (p3_gain_shift),
    .clear_ovf    (p3_clear_ovf),
    .pwm_out      (p3_pwm_out),
    .period_start (p3_period_start),
    .sample_ack   (p3_sample_ack),
    .overflow     (p3_overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Period-level reference model: pending samples, active samples, duty of the running period.
  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] val;
  } load_t;

  load_t      loads[$];
  logic [7:0] m_pend   [4];
  logic [7:0] m_active [4];
  logic [3:0] m_pend_v;
  logic [3:0] m_ack;
  int         m_duty;
  bit         m_ovf;
  bit         m_first;

  task automatic add_load(input int cyc, input int ch, input logic [7:0] val);
    load_t l;
    l.cyc = cyc;
    l.ch  = ch;
    l.val = val;
    loads.push_back(l);
  endtask

  task automatic model_reset();
    m_pend_v = '0;
    m_ack    = '0;
    m_duty   = 0;
    m_ovf    = 1'b0;
    m_first  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_pend[i]   = '0;
      m_active[i] = '0;
    end
  endtask

  // Entered at a negedge with rst_n driven low for the following posedge; returns at cycle 0.
  task automatic do_reset();
    rst_n        = 1'b0;
    sample_valid = '0;
    clear_ovf    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst_pwm_out", pwm_out, 0);
    check("rst_period_start", period_start, 0);
    check("rst_sample_ack", sample_ack, 0);
    check("rst_overflow", overflow, 0);
  endtask

  // Runs one 256-clock period starting at the negedge of its cycle 0. en/gain are the
  // values presented on the wrap cycle; mid-period they are driven with random junk.
  task automatic run_period(input logic [3:0] en, input logic [1:0] gain,
                            input int clr_at, input int abort_at);
    int         exp_d;
    logic [3:0] exp_ack;
    bit         exp_ps;
    int         high, bad_pat, extra_ps, extra_ack, bad_ovf;
    bit         aborted, clr, sat;
    int         sum;
    exp_d     = m_duty;
    exp_ack   = m_ack;
    exp_ps    = !m_first;
    high      = 0;
    bad_pat   = 0;
    extra_ps  = 0;
    extra_ack = 0;
    bad_ovf   = 0;
    aborted   = 1'b0;
    for (int c = 0; c < 256; c++) begin
      if (c == 0) begin
        check("period_start_at_cnt0", period_start, exp_ps);
        check("sample_ack_at_cnt0", sample_ack, exp_ack);
        check("overflow_at_cnt0", overflow, m_ovf);
      end else begin
        if (period_start !== 1'b0) extra_ps++;
        if (sample_ack !== 4'b0) extra_ack++;
      end
      if (pwm_out !== ((c >= 1 && c <= exp_d) ? 1'b1 : 1'b0)) bad_pat++;
      if (pwm_out === 1'b1) high++;
      if (overflow !== m_ovf) bad_ovf++;
      if (c == abort_at) begin
        aborted = 1'b1;
        break;
      end

      sample_in    = $urandom;
      sample_valid = '0;
      ch_enable    = (c == 255) ? en : 4'($urandom);
      gain_shift   = (c == 255) ? gain : 2'($urandom);
      clr          = (c == clr_at);
      clear_ovf    = clr;

      if (c == 255) begin
        m_ack = m_pend_v;
        for (int i = 0; i < 4; i++) begin
          if (m_pend_v[i]) m_active[i] = m_pend[i];
        end
        m_pend_v = '0;
      end
      foreach (loads[k]) begin
        if (loads[k].cyc == c) begin
          sample_in[loads[k].ch*8 +: 8] = loads[k].val;
          sample_valid[loads[k].ch]     = 1'b1;
          m_pend[loads[k].ch]           = loads[k].val;
          m_pend_v[loads[k].ch]         = 1'b1;
        end
      end
      sat = 1'b0;
      if (c == 255) begin
        sum = 0;
        for (int i = 0; i < 4; i++) begin
          if (en[i]) sum += int'(m_active[i]);
        end
        sum     = sum >> gain;
        sat     = (sum > 255);
        m_duty  = sat ? 255 : sum;
        m_first = 1'b0;
      end
      if (sat) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;

      @(negedge clk);
    end
    check("pwm_pattern_errors", bad_pat, 0);
    check("extra_period_start", extra_ps, 0);
    check("extra_sample_ack", extra_ack, 0);
    check("overflow_errors", bad_ovf, 0);
    if (!aborted) check("pwm_high_count", high, exp_d);
    loads.delete();
  endtask

  task automatic do_reset_p3();
    p3_rst_n        = 1'b0;
    p3_sample_valid = '0;
    @(negedge clk);
    p3_rst_n = 1'b1;
    check("p3_rst_pwm_out", p3_pwm_out, 0);
    check("p3_rst_period_start", p3_period_start, 0);
    check("p3_rst_sample_ack", p3_sample_ack, 0);
    check("p3_rst_overflow", p3_overflow, 0);
  endtask

  // One 768-clock period of the PRESCALE=3 instance with ch0 enabled at gain 0.
  task automatic run_period_p3(input int exp_duty, input logic [3:0] exp_ack, input bit exp_ps,
                               input int load_at, input logic [7:0] load_val, input int abort_at);
    int high, bad_pat, extra_ps, extra_ack;
    bit aborted;
    high      = 0;
    bad_pat   = 0;
    extra_ps  = 0;
    extra_ack = 0;
    aborted   = 1'b0;
    for (int r = 0; r < 768; r++) begin
      if (r == 0) begin
        check("p3_period_start_at_cnt0", p3_period_start, exp_ps);
        check("p3_sample_ack_at_cnt0", p3_sample_ack, exp_ack);
      end else begin
        if (p3_period_start !== 1'b0) extra_ps++;
        if (p3_sample_ack !== 4'b0) extra_ack++;
      end
      if (p3_pwm_out !== ((r >= 1 && r <= 3 * exp_duty) ? 1'b1 : 1'b0)) bad_pat++;
      if (p3_pwm_out === 1'b1) high++;
      if (r == abort_at) begin
        aborted = 1'b1;
        break;
      end
      p3_sample_in    = $urandom;
      p3_sample_valid = '0;
      if (r == load_at) begin
        p3_sample_in[7:0]  = load_val;
        p3_sample_valid[0] = 1'b1;
      end
      @(negedge clk);
    end
    check("p3_pwm_pattern_errors", bad_pat, 0);
    check("p3_extra_period_start", extra_ps, 0);
    check("p3_extra_sample_ack", extra_ack, 0);
    if (!aborted) check("p3_pwm_high_count", high, 3 * exp_duty);
  endtask

  initial begin
    rst_n           = 1'b0;
    sample_in       = '0;
    sample_valid    = '0;
    ch_enable       = '0;
    gain_shift      = '0;
    clear_ovf       = 1'b0;
    p3_rst_n        = 1'b0;
    p3_sample_in    = '0;
    p3_sample_valid = '0;
    p3_ch_enable    = 4'b0001;
    p3_gain_shift   = '0;
    p3_clear_ovf    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // First period runs at duty 0; ch0=0x80 becomes active at the first wrap.
    add_load(20, 0, 8'h80);
    run_period(4'b0001, 2'd0, -1, -1);
    // Duty 0x80; stage ch0=ch1=0xC0 for a saturating mix.
    add_load(30, 0, 8'hC0);
    add_load(31, 1, 8'hC0);
    run_period(4'b0011, 2'd0, -1, -1);
    // Saturated at 0xFF with overflow set; clear it and halve the gain.
    run_period(4'b0011, 2'd1, 10, -1);
    // Duty 0xC0; two mid-period loads on ch2, the last one wins.
    add_load(50, 2, 8'h40);
    add_load(100, 2, 8'h20);
    run_period(4'b0100, 2'd0, -1, -1);
    // Duty 0x20 from ch2; ch0=0x30 staged early, 0x10 loaded on the wrap cycle.
    add_load(40, 0, 8'h30);
    add_load(255, 0, 8'h10);
    run_period(4'b0001, 2'd0, -1, -1);
    // Duty 0x30, then the wrap-cycle load 0x10 transfers with a second ack.
    run_period(4'b0001, 2'd0, -1, -1);
    // Duty 0x10; all channels disabled next.
    run_period(4'b0000, 2'd0, -1, -1);
    // Duty 0; load zeros on every channel.
    for (int i = 0; i < 4; i++) add_load(5 + i, i, 8'h00);
    run_period(4'b1111, 2'd0, -1, -1);
    run_period(4'b1111, 2'd3, -1, -1);

    // Randomized periods.
    for (int p = 0; p < 8; p++) begin
      int nl;
      nl = $urandom_range(0, 3);
      for (int k = 0; k < nl; k++) begin
        add_load($urandom_range(0, 255), $urandom_range(0, 3), 8'($urandom));
      end
      run_period(4'($urandom), 2'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : -1, -1);
    end

    // Reset mid-period discards the staged sample and clears the active ones.
    add_load(40, 1, 8'h77);
    run_period(4'b1111, 2'd0, -1, 137);
    do_reset();
    run_period(4'b1111, 2'd0, -1, -1);
    run_period(4'b1111, 2'd0, -1, -1);
    run_period(4'b1111, 2'd0, -1, -1);

    // PRESCALE=3: period of 768 clocks, one count of duty is three clocks high.
    do_reset_p3();
    run_period_p3(0, 4'b0000, 1'b0, 5, 8'h01, -1);
    run_period_p3(1, 4'b0001, 1'b1, -1, 8'h00, -1);
    run_period_p3(1, 4'b0000, 1'b1, 100, 8'h50, 400);
    do_reset_p3();
    run_period_p3(0, 4'b0000, 1'b0, -1, 8'h00, -1);
    run_period_p3(0, 4'b0000, 1'b1, -1, 8'h00, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_mixer.md
Name: pwm_mixer

Overview:
Parametrised successor to the single-channel PWM audio output. Mixes CHANNELS independent WIDTH-bit audio samples into one PWM output. Samples are double-buffered so that channel updates apply only at PWM period boundaries. Adds per-channel enable, global attenuation, saturating mix with a sticky overflow flag, and a per-period sample handshake. Sits between the audio sources (and the SPI-loaded sample path) and the pwm_out pin.

Parameters:
WIDTH, 8, sample width and PWM counter width; period = 2^WIDTH ticks
CHANNELS, 4, number of mixed channels (1..8)
PRESCALE, 1, clk cycles per PWM counter tick (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sample_in  in  CHANNELS*WIDTH  packed samples; channel i at [i*WIDTH +: WIDTH], unsigned
sample_valid  in  CHANNELS  per-channel load strobe for sample_in slice
ch_enable  in  CHANNELS  channel i contributes to mix when 1
gain_shift  in  2  mix right-shift 0..3, sampled at period wrap
clear_ovf  in  1  clears overflow
pwm_out  out  1  registered PWM output
period_start  out  1  one-cycle pulse, first cycle of each period
sample_ack  out  CHANNELS  one-cycle pulse per channel whose staged sample became active
overflow  out  1  sticky, set when the mix saturated

Behaviour:
- Reset (rst_n low at clk edge): prescaler, cnt, all staging and active registers, staged flags, duty, pwm_out, period_start, sample_ack, overflow are all 0.
- Prescaler counts 0..PRESCALE-1. tick = (prescaler == PRESCALE-1). cnt advances by 1 on each tick. With PRESCALE=1, tick is always 1.
- Wrap = tick && cnt == 2^WIDTH-1. On wrap, cnt returns to 0.
- Staging: sample_valid[i] loads stage[i] from its slice and sets staged[i]. A later load before wrap overwrites stage[i]; the last value wins.
- On wrap, for each i with staged[i]=1: active[i] <= stage[i] and staged[i] <= 0. sample_ack[i] and period_start are registered and are high for exactly the cycle after the wrap edge, i.e. the first cycle with cnt=0.
- Simultaneous sample_valid[i] and wrap: the previously staged value (if any) transfers to active. The new value is captured into stage[i] and staged[i] stays 1 for the next period. If nothing was staged, active[i] is unchanged and no ack is issued.
- Mix, evaluated at wrap on the post-transfer active values: sum = Σ active[i] over enabled channels, computed at WIDTH+3 bits. shifted = sum >> gain_shift.
- Saturation: duty = min(shifted, 2^WIDTH-1), registered at wrap. If shifted > 2^WIDTH-1, overflow is set.
- ch_enable and gain_shift changes mid-period have no effect until the next wrap.
- overflow clears on clear_ovf. If set and clear occur in the same cycle, set wins.
- pwm_out(t+1) = (cnt(t) < duty(t)). Latency is one clk.
  - duty 0: low for the whole period.
  - duty 2^WIDTH-1: high for 2^WIDTH-1 of 2^WIDTH ticks.
  - With PRESCALE>1, each tick's level is held for PRESCALE clocks.
- The first period after reset runs with duty 0. Staged samples take effect from the first wrap onward.
- Reset mid-period aborts the period. Staged but unacked samples are discarded.

Test Plan:
1. Defaults (WIDTH=8, CHANNELS=4, PRESCALE=1). After reset, load ch0=0x80, ch_enable=0001, gain 0 -> sample_ack=0001 and period_start on the first cycle with cnt=0; pwm_out then high for exactly 128 of 256 clocks per period; overflow=0.
2. ch0=ch1=0xC0, enable 0011, gain 0 -> duty 0xFF (255 high of 256), overflow=1. Then gain_shift=1, clear_ovf -> next period duty 0xC0, overflow stays 0.
3. Mid-period sample_valid on ch2=0x40, then again with 0x20 -> duty unchanged until wrap. At wrap, active ch2=0x20, single sample_ack[2] pulse, no ack on other channels.
4. Assert sample_valid[0]=0x10 in the wrap cycle, with ch0=0x30 already staged -> this period's duty uses 0x30 and ack[0] pulses. Next wrap: duty 0x10 and a second ack[0].
5. All channels disabled, or all samples 0 -> pwm_out low for the entire period; period_start still pulses every 256 clocks.
6. PRESCALE=3, ch0=0x01 -> period 768 clocks, pwm_out high 3 clocks per period. Assert rst_n low for 1 cycle mid-period -> all outputs 0 next cycle, counter restarts, and the first period has duty 0.
